// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, decoder-facing
// instruction handshake and the execute redirect/fault signals.
interface instruction_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    modport master (
        output mem_req, mem_addr, instruction, instr_valid, pc, misaligned,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instr_valid, pc, misaligned,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads, holds the fetched
// word for the decoder and handles redirects, draining any in-flight read.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    instruction_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, FAULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic        req_q, req_nxt;
    logic        valid_q, valid_nxt;
    logic        mis_q, mis_nxt;
    logic        ack;
    logic        target_ok;

    assign ack       = req_q & bus.mem_ack;
    assign target_ok = (bus.redirect_pc[1:0] == 2'b00);

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.misaligned  = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= 32'h0;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            addr_q   <= addr_nxt;
            instr_q  <= instr_nxt;
            pc_q     <= pc_nxt;
            req_q    <= req_nxt;
            valid_q  <= valid_nxt;
            mis_q    <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = addr_q;
        instr_nxt    = instr_q;
        pc_nxt       = pc_q;
        req_nxt      = req_q;
        valid_nxt    = valid_q;
        mis_nxt      = mis_q;
        if (state == IDLE) begin
            state_nxt = FETCH;
            req_nxt   = 1'b1;
            addr_nxt  = fetch_pc;
        end else if (bus.redirect) begin
            fetch_pc_nxt = bus.redirect_pc;
            valid_nxt    = 1'b0;
            mis_nxt      = !target_ok;
            // An unacknowledged read cannot be withdrawn; wait it out in DRAIN.
            if ((state == FETCH || state == DRAIN) && !ack) begin
                state_nxt = DRAIN;
            end else if (!target_ok) begin
                state_nxt = FAULT;
                req_nxt   = 1'b0;
            end else begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
                addr_nxt  = bus.redirect_pc;
            end
        end else begin
            case (state)
                FETCH: if (ack) begin
                    instr_nxt    = bus.mem_rdata;
                    pc_nxt       = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    valid_nxt    = 1'b1;
                    req_nxt      = 1'b0;
                    state_nxt    = HOLD;
                end
                HOLD: if (bus.instr_ready) begin
                    valid_nxt = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = fetch_pc;
                    state_nxt = FETCH;
                end
                // The fault flag already records whether the drained redirect was bad.
                DRAIN: if (ack) begin
                    if (mis_q) begin
                        req_nxt   = 1'b0;
                        state_nxt = FAULT;
                    end else begin
                        req_nxt   = 1'b1;
                        addr_nxt  = fetch_pc;
                        state_nxt = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder with configurable wait states,
// an in-order stream scoreboard, and directed plus random scenarios.
module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus();
    instruction_fetch #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;
    int sb_checks = 0, sb_errors = 0;
    int max_wait = 0;
    bit rand_wait = 1'b0;
    int cnt = 0, cur_wait = 0;
    int accepted = 0;

    // Memory: answers each request after cur_wait wait cycles with addr^KEY.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.mem_ack = 1'b0;
            cnt = 0;
        end else begin
            if (bus.mem_ack === 1'b1) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end
            bus.mem_rdata = $urandom;
            if (bus.mem_req) begin
                if (cnt == 0) cur_wait = rand_wait ? int'($urandom_range(max_wait, 0)) : max_wait;
                if (cnt >= cur_wait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ KEY;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Scoreboard: the accepted stream is sequential words from the last aligned target.
    logic [31:0] exp_pc = RPC;
    logic [31:0] prev_addr = '0;
    bit fault_exp = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = RPC; fault_exp = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        end else begin
            sb_checks++;
            if (bus.misaligned !== fault_exp) begin
                sb_errors++;
                $display("FAIL sb_misaligned: got %b expected %b at %0t", bus.misaligned, fault_exp, $time);
            end
            if (prev_req && !prev_ack) begin
                sb_checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr) begin
                    sb_errors++;
                    $display("FAIL req_stable: got req=%b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, prev_addr);
                end
            end
            if (bus.mem_req === 1'b1) begin
                sb_checks++;
                if (bus.mem_addr[1:0] !== 2'b00) begin
                    sb_errors++;
                    $display("FAIL addr_aligned: got %h", bus.mem_addr);
                end
            end
            if (fault_exp) begin
                sb_checks++;
                if (bus.instr_valid !== 1'b0) begin
                    sb_errors++;
                    $display("FAIL fault_valid: got %b expected 0", bus.instr_valid);
                end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready && !bus.redirect) begin
                sb_checks++;
                if (bus.pc !== exp_pc || bus.instruction !== (exp_pc ^ KEY)) begin
                    sb_errors++;
                    $display("FAIL stream: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.pc, bus.instruction, exp_pc, exp_pc ^ KEY);
                end
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (bus.redirect) begin
                if (bus.redirect_pc[1:0] == 2'b00) begin
                    exp_pc = bus.redirect_pc;
                    fault_exp = 1'b0;
                end else fault_exp = 1'b1;
            end
            prev_req = bus.mem_req; prev_ack = bus.mem_ack; prev_addr = bus.mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic enter_reset(input int w, input bit rw, input bit rdy);
        rst_n = 1'b0;
        bus.redirect = 1'b0;
        bus.instr_ready = rdy;
        max_wait = w;
        rand_wait = rw;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        enter_reset(0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== RPC) begin errors++; $display("FAIL rst_addr: got %h expected %h", bus.mem_addr, RPC); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", bus.instruction); end
        checks++; if (bus.pc !== RPC) begin errors++; $display("FAIL rst_pc: got %h expected %h", bus.pc, RPC); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", bus.misaligned); end
    endtask

    // Zero-wait memory, ready high: one instruction every two cycles.
    task automatic test_stream();
        tick(); rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            bit ev;
            @(negedge clk);
            if (n <= 2) begin
                checks++;
                if (bus.mem_req !== (n == 2) || (n == 2 && bus.mem_addr !== RPC)) begin
                    errors++; $display("FAIL first_req n=%0d: got req=%b addr=%h expected req=%b addr=%h", n, bus.mem_req, bus.mem_addr, n == 2, RPC);
                end
            end
            ev = (n >= 3) && (n % 2 == 1);
            checks++;
            if (bus.instr_valid !== ev) begin errors++; $display("FAIL stream_valid n=%0d: got %b expected %b", n, bus.instr_valid, ev); end
            if (ev) begin
                logic [31:0] p;
                p = RPC + 32'(4 * ((n - 3) / 2));
                checks++;
                if (bus.pc !== p || bus.instruction !== (p ^ KEY)) begin
                    errors++; $display("FAIL stream_word: got pc=%h instr=%h expected pc=%h instr=%h", bus.pc, bus.instruction, p, p ^ KEY);
                end
            end
        end
    endtask

    task automatic test_wait3();
        int waits = 0, txn = 0;
        logic [31:0] a;
        enter_reset(3, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && txn < 2; i++) begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_ack) waits++;
            else if (bus.mem_req && bus.mem_ack) begin
                a = bus.mem_addr;
                checks++;
                if (waits != 3 || bus.instr_valid !== 1'b0) begin
                    errors++; $display("FAIL wait_ack: got waits=%0d valid=%b expected waits=3 valid=0", waits, bus.instr_valid);
                end
                @(negedge clk);
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.pc !== a) begin
                    errors++; $display("FAIL wait_valid: got valid=%b pc=%h expected valid=1 pc=%h", bus.instr_valid, bus.pc, a);
                end
                waits = 0; txn++;
            end
        end
        checks++; if (txn != 2) begin errors++; $display("FAIL wait_timeout: got %0d transactions expected 2", txn); end
    endtask

    task automatic test_hold();
        logic [31:0] ins, p;
        bit seen = 1'b0;
        enter_reset(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.instr_valid; end
        checks++; if (!seen) begin errors++; $display("FAIL hold_timeout: got no valid expected valid"); end
        ins = bus.instruction; p = bus.pc;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instruction !== ins || bus.pc !== p || bus.mem_req !== 1'b0) begin
                errors++; $display("FAIL hold_stable: got v=%b i=%h pc=%h req=%b expected v=1 i=%h pc=%h req=0",
                                   bus.instr_valid, bus.instruction, bus.pc, bus.mem_req, ins, p);
            end
        end
        tick(); bus.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== p + 32'd4 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: got req=%b addr=%h v=%b expected req=1 addr=%h v=0", bus.mem_req, bus.mem_addr, bus.instr_valid, p + 32'd4);
        end
    endtask

    task automatic test_redirect_drain();
        bit found = 1'b0, acked = 1'b0, done = 1'b0;
        enter_reset(4, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); found = bus.mem_req && bus.mem_addr == 32'h104;
        end
        checks++; if (!found) begin errors++; $display("FAIL drain_find: got no request expected addr 00000104"); end
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        tick(); bus.redirect = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                checks++;
                if (bus.pc !== 32'h200 || bus.instruction !== (32'h200 ^ KEY)) begin
                    errors++; $display("FAIL drain_word: got pc=%h instr=%h expected pc=00000200 instr=%h", bus.pc, bus.instruction, 32'h200 ^ KEY);
                end
                done = 1'b1;
            end
            if (acked) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
                    errors++; $display("FAIL drain_next: got req=%b addr=%h expected req=1 addr=00000200", bus.mem_req, bus.mem_addr);
                end
                acked = 1'b0;
            end
            if (bus.mem_req && bus.mem_ack && bus.mem_addr == 32'h104) acked = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL drain_timeout: got no valid expected pc 00000200"); end
    endtask

    task automatic test_misaligned();
        bit seen = 1'b0;
        enter_reset(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.instr_valid; end
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h202;
        tick(); bus.redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.misaligned !== 1'b1 || bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL mis_fault: got mis=%b req=%b v=%b expected mis=1 req=0 v=0", bus.misaligned, bus.mem_req, bus.instr_valid);
            end
        end
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
        tick(); bus.redirect = 1'b0; bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.misaligned !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin
            errors++; $display("FAIL mis_clear: got mis=%b req=%b addr=%h expected mis=0 req=1 addr=00000300", bus.misaligned, bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h300) begin
            errors++; $display("FAIL mis_word: got v=%b pc=%h expected v=1 pc=00000300", bus.instr_valid, bus.pc);
        end
    endtask

    task automatic test_wrap_reset();
        bit seen = 1'b0;
        int got = 0;
        logic [31:0] want [2];
        want[0] = 32'hFFFF_FFFC; want[1] = 32'h0;
        enter_reset(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.instr_valid; end
        tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.instr_ready = 1'b1;
        tick(); bus.redirect = 1'b0;
        for (int i = 0; i < 30 && got < 2; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                checks++;
                if (bus.pc !== want[got]) begin errors++; $display("FAIL wrap_pc: got %h expected %h", bus.pc, want[got]); end
                got++;
            end
        end
        checks++; if (got != 2) begin errors++; $display("FAIL wrap_timeout: got %0d words expected 2", got); end
        max_wait = 6;
        bus.instr_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.mem_req && !bus.mem_ack && bus.instr_valid == 1'b0; end
        tick(); bus.instr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.instr_valid; end
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== RPC || bus.instruction !== 32'h0 ||
            bus.pc !== RPC || bus.instr_valid !== 1'b0 || bus.misaligned !== 1'b0) begin
            errors++; $display("FAIL async_reset: got req=%b addr=%h i=%h pc=%h v=%b mis=%b expected 0 %h 0 %h 0 0",
                               bus.mem_req, bus.mem_addr, bus.instruction, bus.pc, bus.instr_valid, bus.misaligned, RPC, RPC);
        end
    endtask

    task automatic test_random();
        int start;
        enter_reset(3, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        start = accepted;
        for (int i = 0; i < 1500; i++) begin
            tick();
            bus.redirect = 1'b0;
            bus.instr_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                bus.redirect = 1'b1;
                bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(3, 0) == 0) bus.redirect_pc[1:0] = 2'(1 + $urandom_range(2, 0));
            end
        end
        tick(); bus.redirect = 1'b0;
        repeat (2) tick();
        checks++;
        if (accepted - start < 50) begin errors++; $display("FAIL random_progress: got %0d accepted expected at least 50", accepted - start); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_wait3();
        test_hold();
        test_redirect_drain();
        test_misaligned();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks + sb_checks, errors + sb_errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage that sits directly upstream of `instruction_decoder`. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and captures each returned word into a held instruction register. It presents that word with a valid/ready handshake to the decoder and microcode sequencer. It accepts control-flow redirects from execute, discards any in-flight or stale fetch, and flags misaligned targets.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out 32: read address; always word-aligned.
- `mem_ack` in 1: read data valid this cycle; only meaningful while `mem_req`=1.
- `mem_rdata` in 32: instruction word; sampled when `mem_req`&`mem_ack`.
- `instruction` out 32: held instruction word to the decoder.
- `instr_valid` out 1: `instruction`/`pc` hold a live instruction.
- `instr_ready` in 1: consumer accepts the instruction this cycle.
- `pc` out 32: address of the word in `instruction`.
- `redirect` in 1: control-flow change request from execute.
- `redirect_pc` in 32: new fetch target.
- `misaligned` out 1: sticky fault; last redirect target had `[1:0]`!=0.

## Operation
- Internal `fetch_pc` (32b), 3-bit state: IDLE, FETCH, HOLD, DRAIN, FAULT.
- IDLE: entered on reset. Moves to FETCH on the first clock edge after `rst_n` deasserts.
- FETCH: `mem_req`=1, `mem_addr`=`fetch_pc`.
  - On ack: `instruction`<=`mem_rdata`, `pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4 (mod 2^32, wraps FFFF_FFFC→0), `instr_valid`<=1, go to HOLD.
- HOLD: `mem_req`=0, outputs stable. On `instr_ready`: `instr_valid`<=0, go to FETCH.
- DRAIN: `mem_req`=1, `mem_addr` keeps the old address. On ack, the returned data is discarded and the block goes to FETCH.
- FAULT: `mem_req`=0, `instr_valid`=0, `misaligned`=1. Only a `redirect` leaves this state.
- Request stability rule: once `mem_req` rises, `mem_req` and `mem_addr` hold until `mem_ack`. A request is never withdrawn.
- Redirect has the highest priority and is evaluated in every state except IDLE:
  - `fetch_pc`<=`redirect_pc`, `instr_valid`<=0, and the instruction currently held is dropped.
  - Misaligned target (`redirect_pc[1:0]`!=0): set `misaligned`, go to FAULT. If a request is outstanding without ack, go to DRAIN first, then FAULT instead of FETCH.
  - Aligned target: clear `misaligned`.
    - FETCH without ack this cycle → DRAIN.
    - FETCH with ack the same cycle → data discarded, next state FETCH.
    - HOLD or FAULT → FETCH.
    - DRAIN → stay in DRAIN (new target replaces the old one).
- `instr_ready` is ignored when `instr_valid`=0. If `redirect` and `instr_ready` arrive in the same HOLD cycle, the redirect wins.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`
  - `instruction`=0, `pc`=`RESET_PC`
  - `instr_valid`=0, `misaligned`=0, state IDLE
- Reset asserted mid-transaction aborts immediately; a pending ack is ignored.
- First `mem_req` appears 1 cycle after `rst_n` rises.
- `mem_ack` to `instr_valid`: 1 cycle (registered capture).
- `instr_ready` to next `mem_req`: 1 cycle. Best case is 2 cycles per instruction (zero-wait memory, ready held high).
- Redirect to `mem_req` on the new `redirect_pc`:
  - 1 cycle from HOLD or FAULT.
  - From FETCH or DRAIN: 1 cycle after the outstanding ack.
- `misaligned` rises 1 cycle after the redirect that caused it.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory returning addr^0xA5A5_0000, `instr_ready`=1 → words at 0x100, 0x104, 0x108 appear with matching `pc`, one every 2 cycles.
- Memory with 3 wait cycles; `mem_addr` is checked stable while `mem_req`=1 → `instr_valid` asserts exactly 1 cycle after ack.
- `instr_ready`=0 for 5 cycles in HOLD → `instruction`/`pc` stable, `mem_req`=0; the next fetch starts 1 cycle after ready.
- Redirect to 0x200 during a 4-wait fetch of 0x104 → the ack data for 0x104 never becomes valid; the next `mem_req` has `mem_addr`=0x200.
- Redirect to 0x202 → `misaligned`=1, no requests; a following redirect to 0x300 clears `misaligned` and fetches 0x300.
- Redirect to 0xFFFF_FFFC, two instructions accepted → second `pc`=0x0000_0000; async reset asserted mid-wait forces all outputs to their reset values immediately.
